// File: rtl/ldpc_info_blk_loader_pkg.sv
// Shared types, sizes and the Z mask helper for the LDPC info-block loader.
package ldpc_pkg;

    localparam int NUM_Z         = 3;
    localparam int MAX_Z         = 81;
    localparam int NUM_INFO_BLKS = 20;
    localparam int BLK_IDX_W     = $clog2(NUM_INFO_BLKS);

    // Lifting size selected by each one-hot req_z bit
    localparam int Z_VALUES [NUM_Z] = '{27, 54, 81};

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

    // Ones in bits [Z-1:0] for the Z picked by a one-hot select; all zeros otherwise
    function automatic logic [MAX_Z-1:0] zmask(input logic [NUM_Z-1:0] onehot);
        logic [MAX_Z-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_Z; i++)
            if (onehot[i])
                for (int b = 0; b < MAX_Z; b++)
                    if (b < Z_VALUES[i]) m[b] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ldpc_info_blk_loader_if.sv
// Input stream, output stream and config/status of the info-block loader.
interface ldpc_info_blk_loader_if;
    import ldpc_pkg::*;

    logic [NUM_Z-1:0]     req_z;
    logic                 s_valid;
    logic                 s_ready;
    logic [MAX_Z-1:0]     s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [MAX_Z-1:0]     m_data;
    logic [BLK_IDX_W-1:0] m_blk_idx;
    logic                 m_first;
    logic                 m_last;
    logic [NUM_Z-1:0]     m_z_sel;
    logic                 cfg_err;

    // Environment side: feeds blocks, consumes the replay
    modport master (output req_z, s_valid, s_data, m_ready,
                    input  s_ready, m_valid, m_data, m_blk_idx, m_first, m_last, m_z_sel, cfg_err);

    // Loader side
    modport slave  (input  req_z, s_valid, s_data, m_ready,
                    output s_ready, m_valid, m_data, m_blk_idx, m_first, m_last, m_z_sel, cfg_err);

endinterface

// File: rtl/ldpc_info_blk_loader_bank.sv
// One codeword bank: DEPTH x WIDTH flop storage with async read, plus its latched Z select.
module ldpc_info_bank
    import ldpc_pkg::*;
#(
    parameter int DEPTH = NUM_INFO_BLKS,
    parameter int WIDTH = MAX_Z,
    parameter int ZW    = NUM_Z,
    parameter int AW    = BLK_IDX_W
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             zwe,
    input  logic [ZW-1:0]    zin,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic [ZW-1:0]    z_sel
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Block storage, cleared on reset so no stale codeword can reappear
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)     mem        <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    // Z select captured with the first block of the codeword
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)      z_sel <= '0;
        else if (zwe) z_sel <= zin;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ldpc_info_blk_loader.sv
// Ping-pong loader: fills one bank from the input stream while replaying the other.
module ldpc_info_blk_loader
    import ldpc_pkg::*;
(
    input logic                  CLK,
    input logic                  rst,
    ldpc_info_blk_loader_if.slave bus
);

    localparam logic [BLK_IDX_W-1:0] LAST_IDX = BLK_IDX_W'(NUM_INFO_BLKS - 1);
    localparam logic [BLK_IDX_W-1:0] IDX_ONE  = BLK_IDX_W'(1);

    bank_state_t          bank_st [2];
    bank_state_t          bank_st_n [2];
    logic                 wr_bank, wr_bank_n, rd_bank, rd_bank_n;
    logic [BLK_IDX_W-1:0] wr_idx, wr_idx_n, rd_idx, rd_idx_n;
    logic [1:0][MAX_Z-1:0] rdata;
    logic [1:0][NUM_Z-1:0] zsel;
    logic                 cfg_bad, s_acc, m_acc, cfg_err_q;
    logic [NUM_Z-1:0]     wz;
    logic [MAX_Z-1:0]     wdata;

    // A codeword may only start with a one-hot Z select
    assign cfg_bad = (wr_idx == '0) && !$onehot(bus.req_z);
    assign bus.s_ready = !rst && (bank_st[wr_bank] != FULL) && !cfg_bad;
    assign s_acc = bus.s_valid && bus.s_ready;
    assign m_acc = bus.m_valid && bus.m_ready;

    // Mask with the incoming select on the first block, the latched one afterwards
    assign wz    = (wr_idx == '0) ? bus.req_z : zsel[wr_bank];
    assign wdata = bus.s_data & zmask(wz);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ldpc_info_bank u_bank (
            .CLK   (CLK),
            .rst   (rst),
            .we    (s_acc && (wr_bank == 1'(b))),
            .waddr (wr_idx),
            .wdata (wdata),
            .zwe   (s_acc && (wr_bank == 1'(b)) && (wr_idx == '0)),
            .zin   (bus.req_z),
            .raddr (rd_idx),
            .rdata (rdata[b]),
            .z_sel (zsel[b])
        );
    end

    // Pointer and bank-state registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_idx     <= '0;
            rd_idx     <= '0;
        end else begin
            bank_st <= bank_st_n;
            wr_bank <= wr_bank_n;
            rd_bank <= rd_bank_n;
            wr_idx  <= wr_idx_n;
            rd_idx  <= rd_idx_n;
        end
    end

    // Next state: write and read always target different banks, so both may advance together
    always_comb begin
        bank_st_n = bank_st;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        wr_idx_n  = wr_idx;
        rd_idx_n  = rd_idx;
        if (s_acc) begin
            if (wr_idx == LAST_IDX) begin
                wr_idx_n           = '0;
                bank_st_n[wr_bank] = FULL;
                wr_bank_n          = !wr_bank;
            end else begin
                wr_idx_n           = wr_idx + IDX_ONE;
                bank_st_n[wr_bank] = FILLING;
            end
        end
        if (m_acc) begin
            if (rd_idx == LAST_IDX) begin
                rd_idx_n           = '0;
                bank_st_n[rd_bank] = EMPTY;
                rd_bank_n          = !rd_bank;
            end else begin
                rd_idx_n           = rd_idx + IDX_ONE;
            end
        end
    end

    // One pulse per refused codeword-start attempt
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) cfg_err_q <= 1'b0;
        else     cfg_err_q <= bus.s_valid && cfg_bad && (bank_st[wr_bank] != FULL);
    end

    assign bus.cfg_err   = cfg_err_q;
    assign bus.m_valid   = (bank_st[rd_bank] == FULL);
    assign bus.m_data    = rdata[rd_bank];
    assign bus.m_blk_idx = rd_idx;
    assign bus.m_first   = (rd_idx == '0);
    assign bus.m_last    = (rd_idx == LAST_IDX);
    assign bus.m_z_sel   = zsel[rd_bank];

endmodule

// File: tb/tb_ldpc_info_blk_loader.sv
// Directed + randomized bench for the LDPC info-block loader with an output scoreboard.
module tb_ldpc_info_blk_loader;
    import ldpc_pkg::*;

    typedef struct {
        logic [80:0] d;
        logic [4:0]  idx;
        logic [2:0]  z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errs    = 0;
    int   pops    = 0;
    int   bidx    = 0;
    logic [2:0] bz = 3'b000;
    exp_t q[$];

    ldpc_info_blk_loader_if bif();

    ldpc_info_blk_loader dut (.CLK(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [80:0] zm(input logic [2:0] z);
        int zz;
        logic [80:0] m;
        zz = (z == 3'b001) ? 27 : (z == 3'b010) ? 54 : (z == 3'b100) ? 81 : 0;
        m = '0;
        for (int i = 0; i < 81; i++) m[i] = (i < zz);
        return m;
    endfunction

    function automatic logic [80:0] rnd81();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Hold one block until accepted; record its expected replay on acceptance
    task automatic send(input logic [80:0] d, input logic [2:0] z);
        bit   got = 0;
        int   n   = 0;
        exp_t e;
        bif.s_data  = d;
        bif.req_z   = z;
        bif.s_valid = 1'b1;
        while (!got) begin
            @(negedge clk);
            if (bif.s_ready) begin
                got = 1;
                if (bidx == 0) bz = z;
                e.d   = d & zm(bz);
                e.idx = 5'(bidx);
                e.z   = bz;
                q.push_back(e);
                bidx = (bidx == 19) ? 0 : bidx + 1;
            end
            step();
            n++;
            if (!got && n > 2000) begin
                check("send_timeout", 1, 0);
                got = 1;
            end
        end
        bif.s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    // Output monitor: scoreboard pop per transfer, stability check across stalls
    logic        pv_stall = 1'b0;
    logic [80:0] pv_d;
    logic [4:0]  pv_idx;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bif.m_valid && pv_stall) begin
            check("stall_data", bif.m_data, pv_d);
            check("stall_idx", bif.m_blk_idx, pv_idx);
        end
        pv_stall = !rst && bif.m_valid && !bif.m_ready;
        pv_d     = bif.m_data;
        pv_idx   = bif.m_blk_idx;
        if (!rst && bif.m_valid && bif.m_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = q.pop_front();
                pops++;
                check("out_data", bif.m_data, e.d);
                check("out_idx", bif.m_blk_idx, e.idx);
                check("out_first", bif.m_first, e.idx == 5'd0);
                check("out_last", bif.m_last, e.idx == 5'd19);
                check("out_zsel", bif.m_z_sel, e.z);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pc0;
        bit   dn;
        logic [2:0] rz;
        bif.req_z   = 3'b001;
        bif.s_valid = 1'b0;
        bif.s_data  = '0;
        bif.m_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_s_ready", bif.s_ready, 0);
        check("rst_m_valid", bif.m_valid, 0);
        check("rst_m_data", bif.m_data, 0);
        check("rst_m_idx", bif.m_blk_idx, 0);
        check("rst_m_zsel", bif.m_z_sel, 0);
        check("rst_cfg_err", bif.cfg_err, 0);
        rst = 1'b0;
        step();

        // All-ones, Z=27, latency to first output
        bif.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send({81{1'b1}}, 3'b001);
            if (i == 18) check("lat_not_yet", bif.m_valid, 0);
        end
        check("lat_m_valid", bif.m_valid, 1);
        check("lat_m_first", bif.m_first, 1);
        check("lat_m_data", bif.m_data, 81'h7FFFFFF);
        check("lat_m_zsel", bif.m_z_sel, 3'b001);
        drain();

        // Two codewords buffered with the output blocked
        bif.m_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(rnd81(), 3'b100);
        for (int i = 0; i < 20; i++) send(rnd81(), 3'b010);
        bif.s_data  = rnd81();
        bif.req_z   = 3'b001;
        bif.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_s_ready", bif.s_ready, 0);
            step();
        end
        check("full_m_valid", bif.m_valid, 1);
        check("full_m_zsel", bif.m_z_sel, 3'b100);
        pc0 = pops;
        bif.m_ready = 1'b1;
        send(rnd81(), 3'b001);
        check("no_early_accept", (pops - pc0) >= 20, 1);
        for (int i = 1; i < 20; i++) send(rnd81(), 3'b001);
        drain();

        // Non-one-hot select at codeword start
        bif.s_data  = rnd81();
        bif.req_z   = 3'b011;
        bif.s_valid = 1'b1;
        @(negedge clk);
        check("cfg_s_ready", bif.s_ready, 0);
        step();
        check("cfg_err_pulse", bif.cfg_err, 1);
        send(rnd81(), 3'b100);
        check("cfg_err_clear", bif.cfg_err, 0);
        for (int i = 1; i < 20; i++) send(rnd81(), 3'b100);
        drain();

        // 50 codewords with ~30% output stalls
        dn = 0;
        fork
            begin
                for (int c = 0; c < 50; c++) begin
                    rz = 3'b001 << $urandom_range(0, 2);
                    for (int i = 0; i < 20; i++) send(rnd81(), rz);
                end
                drain();
                dn = 1;
            end
            begin
                while (!dn) begin
                    bif.m_ready = ($urandom_range(0, 99) >= 30);
                    step();
                end
            end
        join
        bif.m_ready = 1'b1;

        // Reset while codeword 1 drains and codeword 2 fills
        for (int i = 0; i < 20; i++) send(rnd81(), 3'b010);
        for (int i = 0; i < 7; i++) send(rnd81(), 3'b001);
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", bif.m_valid, 0);
        check("mid_rst_m_data", bif.m_data, 0);
        check("mid_rst_s_ready", bif.s_ready, 0);
        q.delete();
        bidx = 0;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("post_rst_m_valid", bif.m_valid, 0);
        for (int i = 0; i < 20; i++) send(rnd81(), 3'b100);
        drain();

        // Select change mid-codeword is ignored
        for (int i = 0; i < 20; i++) send({81{1'b1}}, (i < 10) ? 3'b001 : 3'b100);
        drain();

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
